// File: rtl/clk_tick_divider_prog_if.sv
// Handshake/control bundle for clk_tick_divider_prog.
//   en, sync_clr, mode        : counting control
//   div_load, div_val         : divisor load strobe and value
//   tick, oclk                : period strobe and divided clock
//   load_pend, div_act        : divisor shadow status and active divisor
// master drives the controls (system side); slave is the divider.
interface clk_tick_divider_prog_if #(
    parameter int CNT_W = 32
);
    logic             en;
    logic             sync_clr;
    logic             mode;
    logic             div_load;
    logic [CNT_W-1:0] div_val;
    logic             tick;
    logic             oclk;
    logic             load_pend;
    logic [CNT_W-1:0] div_act;

    modport master (
        output en, sync_clr, mode, div_load, div_val,
        input  tick, oclk, load_pend, div_act
    );

    modport slave (
        input  en, sync_clr, mode, div_load, div_val,
        output tick, oclk, load_pend, div_act
    );
endinterface

// File: rtl/clk_tick_divider_prog.sv
// Runtime-programmable tick generator / clock divider.
// Emits a 1-cycle tick every div_act enabled clk cycles and a derived oclk
// (toggle mode: 50% duty at 2*div_act; pulse mode: oclk == tick).
// A new divisor is held in a shadow register and only applied at a period
// boundary (terminal count or sync_clr) so a running period is never cut.
// Ports:
//   clk  : system clock
//   rst  : asynchronous, active-high reset
//   bus  : clk_tick_divider_prog_if.slave (controls in, tick/oclk/status out)
module clk_tick_divider_prog #(
    parameter int CNT_W       = 32,
    parameter int DEFAULT_DIV = 50000
) (
    input  logic                        clk,
    input  logic                        rst,
    clk_tick_divider_prog_if.slave      bus
);
    localparam logic [CNT_W-1:0] DIV_RST =
        (DEFAULT_DIV == 0) ? CNT_W'(1) : CNT_W'(DEFAULT_DIV);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] pending;
    logic [CNT_W-1:0] div_act;
    logic [CNT_W-1:0] val_m;
    logic             tick;
    logic             oclk;
    logic             load_pend;
    logic             term;

    // A divisor of 0 is stored as 1 so div_act - 1 never underflows.
    assign val_m = (bus.div_val == '0) ? CNT_W'(1) : bus.div_val;

    // >= rather than == so a divisor shrink can never let cnt run past terminal.
    assign term = bus.en & ~bus.sync_clr & (cnt >= (div_act - CNT_W'(1)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            pending   <= '0;
            div_act   <= DIV_RST;
            tick      <= 1'b0;
            oclk      <= 1'b0;
            load_pend <= 1'b0;
        end else if (bus.sync_clr) begin
            cnt  <= '0;
            tick <= 1'b0;
            oclk <= 1'b0;
            // A load in the same cycle is newer than the shadow value.
            if (bus.div_load) begin
                div_act   <= val_m;
                load_pend <= 1'b0;
            end else if (load_pend) begin
                div_act   <= pending;
                load_pend <= 1'b0;
            end
        end else if (!bus.en) begin
            tick <= 1'b0;
            if (bus.div_load) begin
                pending   <= val_m;
                load_pend <= 1'b1;
            end
        end else if (term) begin
            cnt       <= '0;
            tick      <= 1'b1;
            oclk      <= bus.mode ? 1'b1 : ~oclk;
            load_pend <= 1'b0;
            if (bus.div_load)
                div_act <= val_m;
            else if (load_pend)
                div_act <= pending;
        end else begin
            cnt  <= cnt + CNT_W'(1);
            tick <= 1'b0;
            if (bus.mode)
                oclk <= 1'b0;
            if (bus.div_load) begin
                pending   <= val_m;
                load_pend <= 1'b1;
            end
        end
    end

    assign bus.tick      = tick;
    assign bus.oclk      = oclk;
    assign bus.load_pend = load_pend;
    assign bus.div_act   = div_act;
endmodule

// File: tb/tb_clk_tick_divider_prog.sv
// Directed bench for clk_tick_divider_prog with DEFAULT_DIV = 5.
module tb_clk_tick_divider_prog;
    localparam int CNT_W = 32;

    logic clk;
    logic rst;
    int   n_pass;
    int   n_chk;

    clk_tick_divider_prog_if #(.CNT_W(CNT_W)) bus ();

    clk_tick_divider_prog #(
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Advance one clock, then check all four outputs.
    task automatic cyc(input string tag, input logic t, input logic o,
                       input logic lp, input logic [31:0] d);
        @(posedge clk);
        #1;
        chk({tag, ".tick"}, 32'(bus.tick), 32'(t));
        chk({tag, ".oclk"}, 32'(bus.oclk), 32'(o));
        chk({tag, ".load_pend"}, 32'(bus.load_pend), 32'(lp));
        chk({tag, ".div_act"}, bus.div_act, d);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".tick"}, 32'(bus.tick), 32'd0);
        chk({tag, ".oclk"}, 32'(bus.oclk), 32'd0);
        chk({tag, ".load_pend"}, 32'(bus.load_pend), 32'd0);
        chk({tag, ".div_act"}, bus.div_act, 32'd5);
    endtask

    initial begin
        n_pass       = 0;
        n_chk        = 0;
        rst          = 1'b1;
        bus.en       = 1'b0;
        bus.sync_clr = 1'b0;
        bus.mode     = 1'b0;
        bus.div_load = 1'b0;
        bus.div_val  = '0;

        // Reset held for 3 cycles.
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        rst    = 1'b0;
        bus.en = 1'b1;

        // Phase 1: toggle mode, divisor 5, 40 enabled cycles.
        for (int n = 1; n <= 40; n++)
            cyc("p1", (n % 5) == 0, ((n / 5) % 2) == 1, 1'b0, 32'd5);

        // Phase 2: load 3 mid-period, applied at the next tick.
        cyc("p2_1", 0, 0, 0, 5);
        cyc("p2_2", 0, 0, 0, 5);
        cyc("p2_3", 0, 0, 0, 5);
        cyc("p2_4", 0, 0, 0, 5);
        cyc("p2_5", 1, 1, 0, 5);
        cyc("p2_6", 0, 1, 0, 5);
        bus.div_load = 1'b1;
        bus.div_val  = 32'd3;
        cyc("p2_7", 0, 1, 1, 5);
        bus.div_load = 1'b0;
        cyc("p2_8", 0, 1, 1, 5);
        cyc("p2_9", 0, 1, 1, 5);
        cyc("p2_10", 1, 0, 0, 3);
        cyc("p2_11", 0, 0, 0, 3);
        cyc("p2_12", 0, 0, 0, 3);
        cyc("p2_13", 1, 1, 0, 3);
        cyc("p2_14", 0, 1, 0, 3);
        cyc("p2_15", 0, 1, 0, 3);
        cyc("p2_16", 1, 0, 0, 3);
        cyc("p2_17", 0, 0, 0, 3);
        cyc("p2_18", 0, 0, 0, 3);
        cyc("p2_19", 1, 1, 0, 3);
        cyc("p2_20", 0, 1, 0, 3);
        cyc("p2_21", 0, 1, 0, 3);

        // Phase 3: load 2 on the terminal edge is applied without pending.
        bus.div_load = 1'b1;
        bus.div_val  = 32'd2;
        cyc("p3_22", 1, 0, 0, 2);
        bus.div_load = 1'b0;
        cyc("p3_23", 0, 0, 0, 2);
        cyc("p3_24", 1, 1, 0, 2);
        cyc("p3_25", 0, 1, 0, 2);
        cyc("p3_26", 1, 0, 0, 2);

        // Back to divisor 5 ahead of the enable-pause test.
        bus.div_load = 1'b1;
        bus.div_val  = 32'd5;
        cyc("p4_ld", 0, 0, 1, 2);
        bus.div_load = 1'b0;
        cyc("p4_tk", 1, 1, 0, 5);
        cyc("p4_c1", 0, 1, 0, 5);
        cyc("p4_c2", 0, 1, 0, 5);

        // Phase 4: en low for 4 cycles at cnt=2; a load is still captured.
        bus.en = 1'b0;
        cyc("p4_off1", 0, 1, 0, 5);
        bus.div_load = 1'b1;
        bus.div_val  = 32'd5;
        cyc("p4_off2", 0, 1, 1, 5);
        bus.div_load = 1'b0;
        cyc("p4_off3", 0, 1, 1, 5);
        cyc("p4_off4", 0, 1, 1, 5);
        bus.en = 1'b1;
        cyc("p4_on3", 0, 1, 1, 5);
        cyc("p4_on4", 0, 1, 1, 5);
        cyc("p4_on5", 1, 0, 0, 5);

        // Phase 5: pulse mode, divisor 0 (-> 1) applied by sync_clr.
        bus.mode     = 1'b1;
        bus.div_load = 1'b1;
        bus.div_val  = 32'd0;
        cyc("p5_ld", 0, 0, 1, 5);
        bus.div_load = 1'b0;
        bus.sync_clr = 1'b1;
        cyc("p5_clr", 0, 0, 0, 1);
        bus.sync_clr = 1'b0;
        cyc("p5_run1", 1, 1, 0, 1);
        cyc("p5_run2", 1, 1, 0, 1);
        cyc("p5_run3", 1, 1, 0, 1);
        bus.sync_clr = 1'b1;
        cyc("p5_hold1", 0, 0, 0, 1);
        cyc("p5_hold2", 0, 0, 0, 1);
        bus.sync_clr = 1'b0;
        cyc("p5_rel", 1, 1, 0, 1);

        // Phase 6: async reset mid-period with a pending load.
        bus.mode     = 1'b0;
        bus.en       = 1'b0;
        bus.div_load = 1'b1;
        bus.div_val  = 32'd3;
        cyc("p6_ld", 0, 1, 1, 1);
        bus.div_load = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        chk_zero("p6_async");
        @(posedge clk);
        #1;
        chk_zero("p6_held");
        rst    = 1'b0;
        bus.en = 1'b1;
        cyc("p6_1", 0, 0, 0, 5);
        cyc("p6_2", 0, 0, 0, 5);
        cyc("p6_3", 0, 0, 0, 5);
        cyc("p6_4", 0, 0, 0, 5);
        cyc("p6_5", 1, 1, 0, 5);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
